// File: rtl/cpu_per_pkg.sv
// Shared definitions for the CPU-side requesters, the arbiter and the peripheral.
package cpu_per_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        XFER    = 2'b01,
        RELEASE = 2'b10
    } state_t;

    localparam int DEF_DATA_W = 2;

endpackage

// File: rtl/cpu_per_arbiter_pick.sv
// Combinational round-robin picker: first set request searching upward from rr_ptr+1 with wrap.
module rr_arb_pick #(
    parameter  int N_REQ = 2,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (req[j] && (j == ((int'(rr_ptr) + k) % N_REQ))) begin
                    idx = IDX_W'(j);
                    vld = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cpu_per_arbiter.sv
// Round-robin arbiter sharing one four-phase peripheral port between N_REQ requesters.
module cpu_per_arbiter
    import cpu_per_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_send,
    input  logic [N_REQ*DATA_W-1:0] req_dado,
    output logic [N_REQ-1:0]        req_ack,
    output logic [N_REQ-1:0]        grant,
    output logic                    per_send,
    output logic [DATA_W-1:0]       per_dado,
    input  logic                    per_ack,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t             state, state_n;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_n, own, own_n;
    logic [CNT_W-1:0]   tmo_cnt, tmo_cnt_n;
    logic [N_REQ-1:0]   grant_n, req_ack_n;
    logic               per_send_n, tmo_n;
    logic [DATA_W-1:0]  per_dado_n;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;

    rr_arb_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req_send),
        .rr_ptr (rr_ptr),
        .idx    (pick_idx),
        .vld    (pick_vld)
    );

    always_comb begin
        state_n    = state;
        rr_ptr_n   = rr_ptr;
        own_n      = own;
        tmo_cnt_n  = tmo_cnt;
        grant_n    = grant;
        req_ack_n  = req_ack;
        per_send_n = per_send;
        per_dado_n = per_dado;
        tmo_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    own_n      = pick_idx;
                    per_send_n = 1'b1;
                    tmo_cnt_n  = '0;
                    state_n    = XFER;
                    for (int j = 0; j < N_REQ; j++) begin
                        grant_n[j] = (j == int'(pick_idx));
                        if (j == int'(pick_idx))
                            per_dado_n = req_dado[j*DATA_W +: DATA_W];
                    end
                end
            end
            XFER: begin
                tmo_cnt_n = tmo_cnt + 1'b1;
                // per_ack is tested first so it beats a coincident terminal count
                if (per_ack) begin
                    per_send_n = 1'b0;
                    req_ack_n  = grant;
                    state_n    = RELEASE;
                end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    per_send_n = 1'b0;
                    req_ack_n  = grant;
                    tmo_n      = 1'b1;
                    state_n    = RELEASE;
                end
            end
            RELEASE: begin
                if (!per_ack && ((req_send & grant) == '0)) begin
                    req_ack_n = '0;
                    grant_n   = '0;
                    rr_ptr_n  = own;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= IDX_W'(N_REQ - 1);
            own         <= '0;
            tmo_cnt     <= '0;
            grant       <= '0;
            req_ack     <= '0;
            per_send    <= 1'b0;
            per_dado    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_ptr_n;
            own         <= own_n;
            tmo_cnt     <= tmo_cnt_n;
            grant       <= grant_n;
            req_ack     <= req_ack_n;
            per_send    <= per_send_n;
            per_dado    <= per_dado_n;
            busy        <= (state_n != IDLE);
            timeout_err <= tmo_n;
        end
    end

endmodule

// File: tb/tb_cpu_per_arbiter.sv
// Scoreboard bench for cpu_per_arbiter: directed scenarios push expected grants/acks, a monitor checks them.
module tb_cpu_per_arbiter;

    localparam int N   = 2;
    localparam int W   = 2;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_send = '0;
    logic [N*W-1:0] req_dado = '0;
    logic           per_ack = 1'b0;
    logic [N-1:0]   req_ack, grant;
    logic           per_send, busy, timeout_err;
    logic [W-1:0]   per_dado;

    cpu_per_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_send    (req_send),
        .req_dado    (req_dado),
        .req_ack     (req_ack),
        .grant       (grant),
        .per_send    (per_send),
        .per_dado    (per_dado),
        .per_ack     (per_ack),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [N-1:0] grant; logic [W-1:0] dado; } start_t;
    typedef struct packed { logic [N-1:0] ack;   logic tmo;          } done_t;

    start_t sq[$];
    done_t  dq[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic exp_start(input logic [N-1:0] g, input logic [W-1:0] d);
        start_t s;
        s.grant = g;
        s.dado  = d;
        sq.push_back(s);
    endtask

    task automatic exp_done(input logic [N-1:0] a, input logic t);
        done_t s;
        s.ack = a;
        s.tmo = t;
        dq.push_back(s);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_send(input logic v, input string nm);
        int n = 0;
        while (per_send !== v && n < 60) begin
            step();
            n++;
        end
        chk(nm, per_send, v);
    endtask

    task automatic wait_ack(input string nm);
        int n = 0;
        while (req_ack == '0 && n < 60) begin
            step();
            n++;
        end
        chk(nm, (req_ack != '0), 1);
    endtask

    // Monitor: pops expectations on per_send and req_ack rising edges.
    logic         prev_send = 1'b0;
    logic [N-1:0] prev_ack  = '0;
    always @(negedge clk) begin
        if (!rst && per_send && !prev_send) begin
            if (sq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_start grant=%0b dado=%0b", grant, per_dado);
            end else begin
                start_t e;
                e = sq.pop_front();
                chk("start_grant", grant, e.grant);
                chk("start_dado", per_dado, e.dado);
            end
        end
        if (!rst && req_ack != '0 && prev_ack == '0) begin
            if (dq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack req_ack=%0b", req_ack);
            end else begin
                done_t e;
                e = dq.pop_front();
                chk("done_ack", req_ack, e.ack);
                chk("done_tmo", timeout_err, e.tmo);
            end
        end
        if (!rst) begin
            chk("inv_grant_onehot0", $onehot0(grant), 1);
            chk("inv_ack_in_grant", req_ack & ~grant, 0);
        end
        prev_send <= per_send;
        prev_ack  <= req_ack;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) step();
        chk("rst_grant", grant, 0);
        chk("rst_req_ack", req_ack, 0);
        chk("rst_per_send", per_send, 0);
        chk("rst_per_dado", per_dado, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tmo", timeout_err, 0);
        rst = 1'b0;

        // Single request
        exp_start(2'b01, 2'b10);
        exp_done(2'b01, 1'b0);
        req_dado = 4'b0010;
        req_send = 2'b01;
        step();
        chk("t1_latency_send", per_send, 1);
        chk("t1_busy", busy, 1);
        repeat (3) step();
        per_ack = 1'b1;
        wait_ack("t1_ack_wait");
        chk("t1_send_dropped", per_send, 0);
        req_send = 2'b00;
        per_ack  = 1'b0;
        step();
        chk("t1_idle_grant", grant, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_ack", req_ack, 0);

        // Contention: alternation 01,10,01,10 from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_dado = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            exp_start((i % 2) ? 2'b10 : 2'b01, (i % 2) ? 2'b11 : 2'b01);
            exp_done((i % 2) ? 2'b10 : 2'b01, 1'b0);
        end
        req_send = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [N-1:0] m;
            m = (i % 2) ? 2'b10 : 2'b01;
            wait_send(1'b1, "t2_send_wait");
            repeat (2) step();
            per_ack = 1'b1;
            wait_ack("t2_ack_wait");
            req_send = req_send & ~m;
            per_ack  = 1'b0;
            step();
            req_send = req_send | m;
        end
        req_send = 2'b00;
        repeat (2) step();

        // Timeout: per_send high exactly TMO cycles, one timeout_err pulse
        exp_start(2'b01, 2'b01);
        exp_done(2'b01, 1'b1);
        req_send = 2'b01;
        wait_send(1'b1, "t3_send_wait");
        begin
            int cnt = 0;
            while (per_send && cnt < 40) begin
                cnt++;
                step();
            end
            chk("t3_send_cycles", cnt, TMO);
        end
        chk("t3_tmo_err", timeout_err, 1);
        chk("t3_req_ack", req_ack, 2'b01);
        step();
        chk("t3_tmo_pulse", timeout_err, 0);
        chk("t3_ack_held", req_ack, 2'b01);
        req_send = 2'b00;
        step();
        chk("t3_idle_busy", busy, 0);

        // Ack coincides with terminal count: ack wins
        exp_start(2'b01, 2'b01);
        exp_done(2'b01, 1'b0);
        req_send = 2'b01;
        wait_send(1'b1, "t4_send_wait");
        repeat (TMO - 1) step();
        chk("t4_still_send", per_send, 1);
        per_ack = 1'b1;
        step();
        chk("t4_ack", req_ack, 2'b01);
        chk("t4_no_tmo", timeout_err, 0);
        req_send = 2'b00;
        per_ack  = 1'b0;
        step();
        chk("t4_idle_busy", busy, 0);

        // Slow release with requester 1 pending
        exp_start(2'b01, 2'b01);
        exp_done(2'b01, 1'b0);
        exp_start(2'b10, 2'b11);
        exp_done(2'b10, 1'b0);
        req_send = 2'b01;
        wait_send(1'b1, "t5_send_wait");
        req_send = 2'b11;
        step();
        per_ack = 1'b1;
        wait_ack("t5_ack_wait");
        req_send = 2'b10;
        repeat (5) begin
            step();
            chk("t5_hold_busy", busy, 1);
            chk("t5_hold_grant", grant, 2'b01);
        end
        per_ack = 1'b0;
        step();
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_grant", grant, 0);
        step();
        chk("t5_next_grant", grant, 2'b10);
        step();
        per_ack = 1'b1;
        wait_ack("t5_ack2_wait");
        req_send = 2'b00;
        per_ack  = 1'b0;
        step();

        // Reset mid-transfer
        exp_start(2'b10, 2'b11);
        req_send = 2'b10;
        wait_send(1'b1, "t6_send_wait");
        step();
        rst = 1'b1;
        step();
        chk("t6_rst_send", per_send, 0);
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_ack", req_ack, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_dado", per_dado, 0);
        chk("t6_rst_tmo", timeout_err, 0);
        rst = 1'b0;
        exp_start(2'b01, 2'b01);
        exp_done(2'b01, 1'b0);
        req_send = 2'b11;
        wait_send(1'b1, "t6_send2_wait");
        chk("t6_first_winner", grant, 2'b01);
        step();
        per_ack = 1'b1;
        wait_ack("t6_ack_wait");
        req_send = 2'b10;
        per_ack  = 1'b0;
        step();
        req_send = 2'b00;
        repeat (3) step();

        chk("sb_start_empty", sq.size(), 0);
        chk("sb_done_empty", dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
